// File: rtl/transpose_switch_ctrl.sv
// transpose_switch_ctrl
// Sequencing controller for the matrix-transpose switch network. It runs one
// matrix job for each accepted start request:
//   - loads N rows,
//   - walks the switch stages in order, giving each stage SETTLE cycles,
//   - drains the transposed rows under output backpressure.
// The block holds no element data. It produces only sequencing strobes and
// the stage selects.
//
// Optional feature: define TRANSPOSE_CTRL_STALL_CNT_EN to build a saturating
// 32-bit counter of DRAIN backpressure cycles. Without it, stall_cycles is
// tied to 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start_valid/ready job request handshake (start_ready decoded from state)
//   transpose_en      sampled at accept; 0 = pass-through for the whole job
//   abort             synchronous cancel, honoured outside IDLE
//   load_en, load_row row-load strobe and row index
//   stage_ctrl        ctrl selects of the switch stages (bit s -> stage s)
//   out_valid/out_row presented output row; out_ready is downstream accept
//   busy, done        not-IDLE flag; one-cycle completion pulse
//   jobs_done         wrapping count of completed jobs
//   stall_cycles      DRAIN backpressure cycles (optional feature)
module transpose_switch_ctrl #(
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int SETTLE = 1,
    parameter int RW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              transpose_en,
    input  logic              abort,
    output logic              load_en,
    output logic [RW-1:0]     load_row,
    output logic [STAGES-1:0] stage_ctrl,
    output logic              out_valid,
    output logic [RW-1:0]     out_row,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       jobs_done,
    output logic [31:0]       stall_cycles
);

    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SWAP, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;        // row counter, shared by LOAD and DRAIN
    logic [SW-1:0] stage_q, stage_d;    // current switch stage in SWAP
    logic [TW-1:0] settle_q, settle_d;  // settle cycles spent on current stage
    logic          te_q, te_d;
    logic          done_q, done_d;
    logic [15:0]   jobs_q, jobs_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stage_q  <= '0;
            settle_q <= '0;
            te_q     <= 1'b0;
            done_q   <= 1'b0;
            jobs_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            settle_q <= settle_d;
            te_q     <= te_d;
            done_q   <= done_d;
            jobs_q   <= jobs_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every variable gets a hold/default value first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        settle_d = settle_q;
        te_d     = te_q;
        done_d   = 1'b0;
        jobs_d   = jobs_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    te_d    = transpose_en;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == RW'(N - 1)) begin
                    state_d  = SWAP;
                    stage_d  = '0;
                    settle_d = '0;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            SWAP: begin
                if (settle_q == TW'(SETTLE - 1)) begin
                    settle_d = '0;
                    if (stage_q == SW'(STAGES - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    settle_d = settle_q + TW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == RW'(N - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        jobs_d  = jobs_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything, including a final DRAIN handshake in the
        // same cycle. The job then counts as cancelled, not completed.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            jobs_d  = jobs_q;
        end
    end

    // Output decode (registered state only)
    always_comb begin
        start_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        load_en     = 1'b0;
        load_row    = '0;
        stage_ctrl  = '0;
        out_valid   = 1'b0;
        out_row     = '0;
        case (state_q)
            LOAD: begin
                load_en  = 1'b1;
                load_row = cnt_q;
            end
            SWAP: begin
                // Stages up to and including the current one are switched.
                for (int k = 0; k < STAGES; k++) begin
                    stage_ctrl[k] = te_q && (k <= int'(stage_q));
                end
            end
            DRAIN: begin
                out_valid  = 1'b1;
                out_row    = cnt_q;
                stage_ctrl = {STAGES{te_q}};
            end
            default: ;
        endcase
    end

    assign done      = done_q;
    assign jobs_done = jobs_q;

`ifdef TRANSPOSE_CTRL_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == DRAIN && !out_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_transpose_switch_ctrl.sv
// Testbench for transpose_switch_ctrl (N=4, STAGES=2, SETTLE=1).
// Table-driven cycle vectors cover three jobs: basic, pass-through and
// backpressure. Hand-written sequences cover abort, back-to-back jobs and a
// reset asserted mid-job.
module tb_transpose_switch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic        transpose_en = 1'b0;
    logic        abort = 1'b0;
    logic        load_en;
    logic [1:0]  load_row;
    logic [1:0]  stage_ctrl;
    logic        out_valid;
    logic [1:0]  out_row;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] jobs_done;
    logic [31:0] stall_cycles;

    int n_total = 0;
    int n_pass  = 0;

    transpose_switch_ctrl #(.N(4), .STAGES(2), .SETTLE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .transpose_en (transpose_en),
        .abort        (abort),
        .load_en      (load_en),
        .load_row     (load_row),
        .stage_ctrl   (stage_ctrl),
        .out_valid    (out_valid),
        .out_row      (out_row),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .jobs_done    (jobs_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic        te;
        logic        ab;
        logic        ordy;
        logic [10:0] exp;  // {sr, le, lr[1:0], sc[1:0], ov, or[1:0], busy, done}
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [10:0] ex(logic sr, logic le, logic [1:0] lr, logic [1:0] sc,
                                       logic ov, logic [1:0] orow, logic bz, logic dn);
        return {sr, le, lr, sc, ov, orow, bz, dn};
    endfunction

    function automatic logic [31:0] outs();
        return {21'd0, start_ready, load_en, load_row, stage_ctrl, out_valid, out_row, busy, done};
    endfunction

    task automatic add(input logic sv, input logic te, input logic ab, input logic ordy,
                       input logic [10:0] e);
        vec_t v;
        v.sv = sv; v.te = te; v.ab = ab; v.ordy = ordy; v.exp = e;
        tbl.push_back(v);
    endtask

    // Expected cycles of one job. Cycle 0 is the accept cycle. With bp set,
    // row 1 is refused for three cycles (cycles 8-10).
    task automatic job_rows(input logic te, input logic bp);
        add(1, te, 0, 1, ex(1, 0, 2'd0, 2'b00, 0, 2'd0, 0, 0));
        for (int r = 0; r < 4; r++) add(0, te, 0, 1, ex(0, 1, 2'(r), 2'b00, 0, 2'd0, 1, 0));
        add(0, te, 0, 1, ex(0, 0, 2'd0, {1'b0, te}, 0, 2'd0, 1, 0));
        add(0, te, 0, 1, ex(0, 0, 2'd0, {te, te}, 0, 2'd0, 1, 0));
        if (!bp) begin
            for (int r = 0; r < 4; r++) add(0, te, 0, 1, ex(0, 0, 2'd0, {te, te}, 1, 2'(r), 1, 0));
        end else begin
            add(0, te, 0, 1, ex(0, 0, 2'd0, {te, te}, 1, 2'd0, 1, 0));
            for (int k = 0; k < 3; k++) add(0, te, 0, 0, ex(0, 0, 2'd0, {te, te}, 1, 2'd1, 1, 0));
            add(0, te, 0, 1, ex(0, 0, 2'd0, {te, te}, 1, 2'd1, 1, 0));
            add(0, te, 0, 1, ex(0, 0, 2'd0, {te, te}, 1, 2'd2, 1, 0));
            add(0, te, 0, 1, ex(0, 0, 2'd0, {te, te}, 1, 2'd3, 1, 0));
        end
        add(0, te, 0, 1, ex(1, 0, 2'd0, 2'b00, 0, 2'd0, 0, 1));
    endtask

    initial begin
        logic [31:0] exp_stall;
        logic        bad;
        logic [15:0] jobs_before;

`ifdef TRANSPOSE_CTRL_STALL_CNT_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif

        job_rows(1'b1, 1'b0);  // basic job: done in cycle 11
        job_rows(1'b0, 1'b0);  // pass-through: stage_ctrl stays 0, done in cycle 11
        job_rows(1'b1, 1'b1);  // backpressure: done in cycle 14

        // Reset held, then released.
        repeat (2) @(negedge clk);
        check("reset_jobs", {16'd0, jobs_done}, 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        rst = 1'b1;

        // Table-driven vectors
        foreach (tbl[i]) begin
            @(negedge clk);
            start_valid  = tbl[i].sv;
            transpose_en = tbl[i].te;
            abort        = tbl[i].ab;
            out_ready    = tbl[i].ordy;
            check($sformatf("vec%0d", i), outs(), {21'd0, tbl[i].exp});
        end
        @(negedge clk);
        start_valid = 1'b0;
        out_ready   = 1'b1;
        check("table_jobs_done", {16'd0, jobs_done}, 32'd3);
        check("table_stall_cycles", stall_cycles, exp_stall);

        // Abort raised in cycle 6 (second SWAP cycle)
        jobs_before = jobs_done;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            start_valid  = (c == 0);
            transpose_en = 1'b1;
            abort        = (c == 6);
            if (c == 0) check("abort_accept", {31'd0, start_ready}, 32'd1);
            if (c == 6) check("abort_swap_ctrl", {30'd0, stage_ctrl}, 32'd3);
            if (c == 7) check("abort_idle", {29'd0, busy, start_ready, done}, 32'b010);
        end
        bad = 1'b0;
        for (int c = 8; c < 16; c++) begin
            @(negedge clk);
            if (done !== 1'b0) bad = 1'b1;
        end
        check("abort_no_done", {31'd0, bad}, 32'd0);
        check("abort_jobs_unchanged", {16'd0, jobs_done}, {16'd0, jobs_before});

        // Back-to-back jobs with start_valid held high
        bad = 1'b0;
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            start_valid  = (c != 22);
            transpose_en = 1'b1;
            out_ready    = 1'b1;
            if (c == 0) check("b2b_accept0", {31'd0, start_ready}, 32'd1);
            if (c >= 1 && c <= 10 && (start_ready !== 1'b0 || busy !== 1'b1)) bad = 1'b1;
            if (c == 11) check("b2b_done1", {30'd0, done, start_ready}, 32'b11);
            if (c == 12) check("b2b_load2", {29'd0, load_en, load_row}, 32'b100);
            if (c == 21) check("b2b_no_early_done", {31'd0, done}, 32'd0);
            if (c == 22) check("b2b_done2", {31'd0, done}, 32'd1);
        end
        check("b2b_busy_not_ready", {31'd0, bad}, 32'd0);
        check("b2b_jobs_done", {16'd0, jobs_done}, 32'd5);

        // Reset asserted mid-DRAIN
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            start_valid = (c == 0);
            if (c == 8) check("rst_pre_drain", {31'd0, out_valid}, 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        check("rst_outputs", {21'd0, 1'b0, load_en, load_row, stage_ctrl, out_valid, out_row, busy, done}, 32'd0);
        check("rst_counters", {16'd0, jobs_done} | stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release", {29'd0, start_ready, busy, done}, 32'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
